layer_output_serializer: RTL and testbench
==========================================

LAYER_OUTPUT_SERIALIZER -- requirements
Module: layer_output_serializer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 30, the number of neuron outputs per frame (legal range 2..1024).
REQ-002 SHALL have parameter data_width, default 16, the width of each neuron output word.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port in_data, input, NUM_NEURONS*data_width, the parallel layer outputs; word k occupies bits [k*data_width +: data_width].
REQ-006 SHALL have port in_valid, input, 1, asserted by the producing layer when all neuron outputs are valid.
REQ-007 SHALL have port in_ready, output, 1, asserted when a frame can be captured this cycle.
REQ-008 SHALL have port out_data, output, data_width, the serial word presented to the next layer.
REQ-009 SHALL have port out_valid, output, 1, asserted when out_data holds a valid word.
REQ-010 SHALL have port out_ready, input, 1, asserted by the downstream consumer to accept a word.
REQ-011 SHALL have port out_last, output, 1, asserted with the final word (index NUM_NEURONS-1) of a frame.
REQ-012 SHALL have port out_index, output, clog2(NUM_NEURONS), the index of the word currently on out_data.
REQ-013 SHALL have port frame_cnt, output, 16, the count of fully transmitted frames, wrapping from 0xFFFF to 0.

Function
REQ-014 SHALL implement two states: IDLE (no frame held) and SEND (frame held, words being emitted).
REQ-015 SHALL drive in_ready high in IDLE, and also in SEND in the cycle where out_index==NUM_NEURONS-1 and out_ready==1; it SHALL be low otherwise.
REQ-016 SHALL capture in_data into an internal frame buffer on a cycle with in_valid&&in_ready, set out_index=0 and enter SEND on the next cycle.
REQ-017 SHALL emit the first word in the cycle after capture, giving 1-cycle capture-to-out_valid latency.
REQ-018 SHALL hold out_valid high throughout SEND and low throughout IDLE.
REQ-019 SHALL transfer a word on each cycle with out_valid&&out_ready, and SHALL then increment out_index.
REQ-020 SHALL keep out_data, out_index and out_last stable while out_valid&&!out_ready (stall).
REQ-021 SHALL emit words in ascending index order 0..NUM_NEURONS-1, with out_last==(out_index==NUM_NEURONS-1).
REQ-022 SHALL increment frame_cnt by 1 when the last word transfers.
REQ-023 When the last word transfers, the block SHALL return to IDLE, unless in_valid is high in that same cycle.
REQ-024 If in_valid is high in the cycle the last word transfers, the block SHALL capture the new frame, remain in SEND and restart at index 0, with no bubble cycle.
REQ-025 SHALL ignore in_data and in_valid while in_ready is low; the producer is required to hold in_valid until it is accepted.
REQ-026 SHALL NOT change the buffered frame mid-frame regardless of in_data activity.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL enter IDLE and clear out_valid, out_last, out_index, out_data and frame_cnt to 0.
REQ-028 Reset SHALL take priority over all other activity, including mid-frame; a partially sent frame SHALL be discarded.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-030 With macro SERIALIZER_RELU_EN defined, out_data SHALL equal 0 whenever the buffered word is negative (MSB=1, two's complement), and SHALL equal the word otherwise.
REQ-031 Without SERIALIZER_RELU_EN, out_data SHALL equal the buffered word unmodified.
REQ-032 The macro SHALL NOT affect timing, handshakes or port list.

Verification
REQ-033 Bench with NUM_NEURONS=4 and data_width=16: capture {0x0004,0x0003,0x0002,0x0001} (word0=0x0001) with out_ready=1 -> out_data 0x0001,0x0002,0x0003,0x0004 on four consecutive cycles; out_last only on 0x0004; frame_cnt=1.
REQ-034 Same frame with out_ready low for cycles 2-4 of the frame -> out_data=0x0002 and out_index=1 held stable, then resume; all four words are delivered exactly once.
REQ-035 Second frame with in_valid high during the last-word transfer -> in_ready=1 in that cycle, the next cycle shows index 0 of the new frame, with no idle gap; frame_cnt=2.
REQ-036 Assert rst after two words are transferred -> next cycle out_valid=0, frame_cnt=0, in_ready=1; a new frame then starts at index 0.
REQ-037 Word0=0xFFF0 -> out_data=0x0000 with SERIALIZER_RELU_EN defined, and 0xFFF0 without it.
REQ-038 Preload frame_cnt to 0xFFFF via 65535 frames (or force), then send one frame -> frame_cnt=0x0000.

Source files
------------

// File: rtl/layer_output_serializer.sv
// layer_output_serializer
//   Captures one frame of NUM_NEURONS parallel neuron outputs and replays it as
//   a valid/ready word stream in ascending index order, counting completed frames.
//   A new frame can be captured in the same cycle the last word leaves, so
//   back-to-back frames stream with no bubble.
//   Optional build macro: SERIALIZER_RELU_EN -- clamps negative (MSB set)
//   words to zero on out_data; timing and handshakes are unchanged.

module layer_output_serializer #(
   parameter int NUM_NEURONS = 30,
   parameter int data_width  = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_NEURONS*data_width-1:0]     in_data,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   output logic [data_width-1:0]                 out_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  out_last,
   output logic [$clog2(NUM_NEURONS)-1:0]        out_index,
   output logic [15:0]                           frame_cnt
);

   localparam int IDX_W = $clog2(NUM_NEURONS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // Output word shaping: optional rectification of negative words.
   function automatic logic [data_width-1:0] shape_word(input logic [data_width-1:0] w);
`ifdef SERIALIZER_RELU_EN
      if (w[data_width-1] == 1'b1) begin
         shape_word = {data_width{1'b0}};
      end else begin
         shape_word = w;
      end
`else
      shape_word = w;
`endif
   endfunction

   logic [0:0]                         state_r;
   logic [0:0]                         state_s;
   logic [NUM_NEURONS*data_width-1:0]  frame_r;
   logic [NUM_NEURONS*data_width-1:0]  frame_s;
   logic [IDX_W-1:0]                   index_r;
   logic [IDX_W-1:0]                   index_s;
   logic [IDX_W-1:0]                   next_idx_s;
   logic [data_width-1:0]              data_r;
   logic [data_width-1:0]              data_s;
   logic                               last_r;
   logic                               last_s;
   logic [15:0]                        frame_cnt_r;
   logic [15:0]                        frame_cnt_s;
   logic                               in_ready_s;
   logic                               capture_s;
   logic                               xfer_s;

   // Handshake decode: accept a frame when idle or while the last word is leaving.
   always_comb begin
      in_ready_s = 1'b0;
      if (state_r == ST_IDLE) begin
         in_ready_s = 1'b1;
      end else if ((last_r == 1'b1) && (out_ready == 1'b1)) begin
         in_ready_s = 1'b1;
      end else begin
         in_ready_s = 1'b0;
      end
      capture_s  = in_valid && in_ready_s;
      xfer_s     = (state_r == ST_SEND) && out_ready;
      next_idx_s = index_r + {{(IDX_W-1){1'b0}}, 1'b1};
   end

   // Next-state logic for the FSM, frame buffer, output word and frame counter.
   always_comb begin
      state_s     = state_r;
      frame_s     = frame_r;
      index_s     = index_r;
      data_s      = data_r;
      last_s      = last_r;
      frame_cnt_s = frame_cnt_r;

      if (capture_s) begin
         // New frame (from idle, or chained onto the last word of the previous one).
         frame_s = in_data;
         state_s = ST_SEND;
         index_s = {IDX_W{1'b0}};
         data_s  = shape_word(in_data[data_width-1:0]);
         last_s  = 1'b0;
      end else if (xfer_s) begin
         if (last_r) begin
            state_s = ST_IDLE;
            index_s = {IDX_W{1'b0}};
            data_s  = {data_width{1'b0}};
            last_s  = 1'b0;
         end else begin
            index_s = next_idx_s;
            data_s  = shape_word(frame_r[int'(next_idx_s)*data_width +: data_width]);
            last_s  = (next_idx_s == LAST_IDX);
         end
      end else begin
         // Idle with nothing offered, or stalled: hold everything.
         state_s = state_r;
      end

      if (xfer_s && last_r) begin
         frame_cnt_s = frame_cnt_r + 16'd1;
      end else begin
         frame_cnt_s = frame_cnt_r;
      end
   end

   // State registers with synchronous reset; reset drops any partial frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         frame_r     <= {(NUM_NEURONS*data_width){1'b0}};
         index_r     <= {IDX_W{1'b0}};
         data_r      <= {data_width{1'b0}};
         last_r      <= 1'b0;
         frame_cnt_r <= 16'd0;
      end else begin
         state_r     <= state_s;
         frame_r     <= frame_s;
         index_r     <= index_s;
         data_r      <= data_s;
         last_r      <= last_s;
         frame_cnt_r <= frame_cnt_s;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = (state_r == ST_SEND);
   assign out_data  = data_r;
   assign out_last  = last_r;
   assign out_index = index_r;
   assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed testbench for layer_output_serializer (NUM_NEURONS=4, data_width=16).
// Build with or without SERIALIZER_RELU_EN; expectations follow the macro.

module tb_layer_output_serializer;

   localparam int NN = 4;
   localparam int DW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NN*DW-1:0]  in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [1:0]        out_index;
   logic [15:0]       frame_cnt;

   int          cmp_cnt = 0;
   int          err_cnt = 0;
   logic [15:0] exp_cnt = 16'd0;

   logic [NN*DW-1:0] f1 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
   logic [NN*DW-1:0] f2 = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
   logic [NN*DW-1:0] f3 = {16'h0024, 16'h0023, 16'h0022, 16'h0021};
   logic [NN*DW-1:0] f5 = {16'h8000, 16'h7FFF, 16'h0005, 16'hFFF0};

   layer_output_serializer #(.NUM_NEURONS(NN), .data_width(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_index (out_index),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] relu_model(input logic [15:0] w);
`ifdef SERIALIZER_RELU_EN
      return w[15] ? 16'h0000 : w;
`else
      return w;
`endif
   endfunction

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input string tag, input logic [15:0] d, input int idx);
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_data"},  32'(out_data),  32'(d));
      check_eq({tag, "_index"}, 32'(out_index), 32'(idx));
      check_eq({tag, "_last"},  32'(out_last),  (idx == NN-1) ? 32'd1 : 32'd0);
   endtask

   // Capture one frame and drain it at full rate, scrambling in_data meanwhile.
   task automatic run_frame(input string tag, input logic [NN*DW-1:0] f);
      logic [NN*DW-1:0] fv;
      fv = f;
      next_cycle;
      in_data = fv; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check_eq({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
      for (int k = 0; k < NN; k++) begin
         next_cycle;
         in_valid = 1'b0;
         in_data  = {4{16'hBAD0}};
         #1;
         expect_word(tag, relu_model(fv[k*DW +: DW]), k);
         check_eq({tag, "_rdy_send"}, 32'(in_ready), (k == NN-1) ? 32'd1 : 32'd0);
      end
      next_cycle;
      exp_cnt = exp_cnt + 16'd1;
      #1;
      check_eq({tag, "_idle"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_cnt"},  32'(frame_cnt), 32'(exp_cnt));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (2) next_cycle;
      #1;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_last",  32'(out_last),  32'd0);
      check_eq("rst_index", 32'(out_index), 32'd0);
      check_eq("rst_data",  32'(out_data),  32'd0);
      check_eq("rst_cnt",   32'(frame_cnt), 32'd0);
      next_cycle;
      rst = 1'b0;
      #1;
      check_eq("post_rst_rdy", 32'(in_ready), 32'd1);

      // Basic frame at full rate.
      run_frame("basic", f1);

      // Stall: word0 transfers, then out_ready low for three cycles with in_valid noise.
      next_cycle;
      in_data = f1; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      next_cycle;
      in_valid = 1'b0;
      #1;
      expect_word("stall_w0", 16'h0001, 0);
      next_cycle;
      out_ready = 1'b0; in_valid = 1'b1; in_data = f3;
      #1;
      expect_word("stall_a", 16'h0002, 1);
      check_eq("stall_a_rdy", 32'(in_ready), 32'd0);
      repeat (2) begin
         next_cycle;
         #1;
         expect_word("stall_b", 16'h0002, 1);
         check_eq("stall_b_rdy", 32'(in_ready), 32'd0);
      end
      next_cycle;
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      expect_word("stall_w1", 16'h0002, 1);
      next_cycle;
      #1;
      expect_word("stall_w2", 16'h0003, 2);
      next_cycle;
      #1;
      expect_word("stall_w3", 16'h0004, 3);
      next_cycle;
      exp_cnt = exp_cnt + 16'd1;
      #1;
      check_eq("stall_idle", 32'(out_valid), 32'd0);
      check_eq("stall_cnt",  32'(frame_cnt), 32'(exp_cnt));

      // Back-to-back: next frame offered during the last-word transfer.
      next_cycle;
      in_data = f2; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      next_cycle;
      in_valid = 1'b0;
      #1;
      expect_word("b2b_w0", 16'h000A, 0);
      next_cycle;
      #1;
      expect_word("b2b_w1", 16'h000B, 1);
      next_cycle;
      #1;
      expect_word("b2b_w2", 16'h000C, 2);
      next_cycle;
      in_data = f3; in_valid = 1'b1;
      #1;
      expect_word("b2b_w3", 16'h000D, 3);
      check_eq("b2b_rdy", 32'(in_ready), 32'd1);
      next_cycle;
      in_valid = 1'b0; in_data = {4{16'hBAD0}};
      exp_cnt = exp_cnt + 16'd1;
      #1;
      expect_word("b2b_n0", 16'h0021, 0);
      check_eq("b2b_cnt", 32'(frame_cnt), 32'(exp_cnt));
      next_cycle;
      #1;
      expect_word("b2b_n1", 16'h0022, 1);
      next_cycle;
      #1;
      expect_word("b2b_n2", 16'h0023, 2);
      next_cycle;
      #1;
      expect_word("b2b_n3", 16'h0024, 3);
      next_cycle;
      exp_cnt = exp_cnt + 16'd1;
      #1;
      check_eq("b2b_idle", 32'(out_valid), 32'd0);
      check_eq("b2b_cnt2", 32'(frame_cnt), 32'(exp_cnt));

      // Reset mid-frame after two words have transferred.
      next_cycle;
      in_data = f1; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      next_cycle;
      in_valid = 1'b0;
      #1;
      expect_word("mid_w0", 16'h0001, 0);
      next_cycle;
      #1;
      expect_word("mid_w1", 16'h0002, 1);
      next_cycle;
      rst = 1'b1;
      #1;
      expect_word("mid_w2", 16'h0003, 2);
      next_cycle;
      rst = 1'b0;
      exp_cnt = 16'd0;
      #1;
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_cnt",   32'(frame_cnt), 32'd0);
      check_eq("mid_rst_rdy",   32'(in_ready),  32'd1);
      check_eq("mid_rst_index", 32'(out_index), 32'd0);
      run_frame("after_rst", f2);

      // Negative words: clamped only when the rectifier is built in.
      run_frame("relu", f5);
`ifdef SERIALIZER_RELU_EN
      check_eq("relu_const", 32'(relu_model(16'hFFF0)), 32'h0000_0000 | 32'(frame_cnt & 16'h0000));
`endif

      // Counter wrap: preload 0xFFFF, one more frame rolls it to zero.
      next_cycle;
      force dut.frame_cnt_r = 16'hFFFF;
      next_cycle;
      release dut.frame_cnt_r;
      exp_cnt = 16'hFFFF;
      #1;
      check_eq("wrap_pre", 32'(frame_cnt), 32'h0000_FFFF);
      run_frame("wrap", f1);
      check_eq("wrap_zero", 32'(frame_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
